nebula_link_vc_tx: RTL and testbench
====================================

Name: nebula_link_vc_tx

Overview:
- Parametrised multi-VC transmit front end for a Nebula link.
- Takes NUM_VC per-VC flit streams and arbitrates them onto one registered TX flit channel.
- Gates each VC on a per-VC credit counter; counters are replenished by credit returns from the far end.
- Holds packet atomicity: once a head flit wins, that VC keeps the link until its tail. Sits between router output ports and the physical link serdes.

Parameters:
- FLIT_W, 64, flit width in bits; bits [FLIT_W-1:FLIT_W-2] hold the flit type (00 body, 01 head, 10 tail, 11 single).
- NUM_VC, 4, number of virtual channels (2..8).
- VC_W, 3, VC index width; must satisfy 2**VC_W >= NUM_VC.
- CREDITS_INIT, 8, per-VC credit count loaded at reset; equals far-end buffer depth.
- CNT_W, 4, credit counter width; must satisfy 2**CNT_W > CREDITS_INIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  NUM_VC  per-VC flit valid
- in_flit  in  NUM_VC*FLIT_W  per-VC flits, VC v at [v*FLIT_W +: FLIT_W]
- in_ready  out  NUM_VC  per-VC accept
- tx_valid  out  1  link flit valid
- tx_flit  out  FLIT_W  link flit
- tx_vc  out  VC_W  VC of tx_flit
- rx_ready  in  1  link backpressure
- credit_rx_valid  in  1  one credit returned this cycle
- credit_rx_vc  in  VC_W  VC of the returned credit
- credit_cnt  out  NUM_VC*CNT_W  current per-VC credits
- credit_err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at a clk edge) gives:
  - tx_valid=0, tx_flit=0, tx_vc=0
  - every credit counter = CREDITS_INIT
  - lock cleared, round-robin pointer = 0, credit_err = 0
  - in_ready = 0 while rst is high
- Reset mid-packet discards the lock and any flit held in the output register. No flit is emitted after reset until a new grant.
- Output register:
  - load_en = !tx_valid | rx_ready.
  - tx_valid, tx_flit and tx_vc are held stable while tx_valid & !rx_ready.
- Eligibility of VC v: in_valid[v] & credit[v] != 0 & (lock inactive | lock_vc == v).
- Arbitration:
  - Round-robin starting at the pointer; at most one in_ready bit is high per cycle.
  - in_ready[g] = load_en & eligible[g] for the winner g only.
  - A flit accepted in cycle N appears on tx_* in cycle N+1. Sustained throughput is 1 flit/cycle.
- Lock:
  - Accepted type 01 (head) sets the lock to that VC.
  - Accepted type 10 (tail) clears the lock.
  - Types 11 (single) and 00 (body) leave the lock unchanged.
  - While locked, no other VC may win, even if the locked VC has no credit.
- Pointer: advances to g+1 (mod NUM_VC) on acceptance of a head or single flit. It does not move on body or tail flits.
- Credits:
  - Decrement on acceptance (in_valid & in_ready), not on link transfer.
  - Increment on credit_rx_valid for credit_rx_vc.
  - Consume and return on the same VC in the same cycle: net unchanged.
- Credit return error cases (credit_err set, sticky until rst):
  - Return to a counter already at CREDITS_INIT: counter saturates at CREDITS_INIT.
  - credit_rx_vc >= NUM_VC: return ignored.
- A credit that reaches zero blocks its VC starting the next cycle. A credit returned in cycle N makes the VC eligible in cycle N+1.
- Body or tail flit from an unlocked VC: accepted and forwarded unchanged; no error. Upstream guarantees framing.

Optional Feature:
- Macro: NEBULA_LINK_VC_STATS_EN.
- When defined, the block adds:
  - output stat_flits, NUM_VC*32: per-VC count of flits transferred on the link (tx_valid & rx_ready). Wraps at 2**32; cleared by rst.
  - output stat_stall, NUM_VC*32: per-VC count of cycles with in_valid[v]=1 and credit[v]=0. Wraps at 2**32; cleared by rst.
- When not defined, these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then VC0 sends a single flit (type 11), rx_ready=1 -> tx_valid=1, tx_vc=0 one cycle later; credit_cnt[0]=7.
- VC0 and VC1 both continuously send single flits, rx_ready=1, no credit returns -> tx_vc alternates 0,1,0,1…; both counters reach 0 after 16 flits; tx_valid=0 afterwards.
- VC1 sends head, body, body, tail while VC2 has pending singles -> four VC1 flits contiguous on tx; VC2's first flit follows the tail.
- Hold rx_ready=0 for 5 cycles with a flit in the output register -> tx_flit/tx_vc stable and in_ready=0 throughout; the flit transfers once rx_ready rises.
- Credit of VC2 at 0 with a flit pending; credit_rx_valid=1, credit_rx_vc=2 in cycle N -> in_ready[2]=1 in cycle N+1; simultaneous consume+return leaves the count unchanged.
- Credit return to VC3 at 8, then to VC index 5 with NUM_VC=4 -> counter stays 8, credit_err=1 and remains 1 until rst.

Source files
------------

// File: rtl/nebula_link_vc_tx.sv
// Multi-VC credit-gated transmit front end: round-robin arbitration with packet lock onto one registered link.
// Optional per-VC statistics counters are enabled by defining NEBULA_LINK_VC_STATS_EN.
module nebula_link_vc_tx #(
    parameter int unsigned FLIT_W       = 64,
    parameter int unsigned NUM_VC       = 4,
    parameter int unsigned VC_W         = 3,
    parameter int unsigned CREDITS_INIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_VC-1:0]        in_valid,
    input  logic [NUM_VC*FLIT_W-1:0] in_flit,
    output logic [NUM_VC-1:0]        in_ready,
    output logic                     tx_valid,
    output logic [FLIT_W-1:0]        tx_flit,
    output logic [VC_W-1:0]          tx_vc,
    input  logic                     rx_ready,
    input  logic                     credit_rx_valid,
    input  logic [VC_W-1:0]          credit_rx_vc,
    output logic [NUM_VC*CNT_W-1:0]  credit_cnt,
    output logic                     credit_err
`ifdef NEBULA_LINK_VC_STATS_EN
    ,
    output logic [NUM_VC*32-1:0]     stat_flits,
    output logic [NUM_VC*32-1:0]     stat_stall
`endif
);

    typedef enum logic {LK_IDLE, LK_HELD} lock_e;

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS_INIT);
    localparam logic [VC_W:0]    NUM_VC_L = (VC_W+1)'(NUM_VC);
    localparam logic [1:0]       FT_HEAD  = 2'b01;
    localparam logic [1:0]       FT_TAIL  = 2'b10;

    logic              tx_valid_q, tx_valid_d;
    logic [FLIT_W-1:0] tx_flit_q, tx_flit_d;
    logic [VC_W-1:0]   tx_vc_q, tx_vc_d;
    lock_e             lock_q, lock_d;
    logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
    logic              lock_active;
    logic [VC_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cred_q [NUM_VC];
    logic [CNT_W-1:0]  cred_d [NUM_VC];
    logic              err_q, err_d;

    logic              load_en;
    logic [NUM_VC-1:0] eligible;
    logic              win_found;
    logic [VC_W-1:0]   win_vc, win_next;
    logic [FLIT_W-1:0] win_flit;
    logic [1:0]        win_type;
    logic              accept;

    assign load_en  = !tx_valid_q || rx_ready;
    assign win_type = win_flit[FLIT_W-1 -: 2];
    assign accept   = |in_ready;

    always_comb begin
        eligible = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            eligible[v] = in_valid[v] && (cred_q[v] != '0)
                          && (!lock_active || lock_vc_q == VC_W'(v));
        end
    end

    // Two passes give round-robin order: first VCs at/above the pointer, then the wrapped ones.
    always_comb begin
        win_found = 1'b0;
        win_vc    = '0;
        win_next  = '0;
        win_flit  = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (!win_found && eligible[v]
                    && ((p == 0) ? (VC_W'(v) >= ptr_q) : (VC_W'(v) < ptr_q))) begin
                    win_found = 1'b1;
                    win_vc    = VC_W'(v);
                    win_next  = (v == NUM_VC - 1) ? '0 : VC_W'(v + 1);
                    win_flit  = in_flit[v*FLIT_W +: FLIT_W];
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            in_ready[v] = !rst && load_en && win_found && (win_vc == VC_W'(v));
        end
    end

    // Lock FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= LK_IDLE;
            lock_vc_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    // Lock FSM: next state
    always_comb begin
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        if (accept) begin
            if (win_type == FT_HEAD) begin
                lock_d    = LK_HELD;
                lock_vc_d = win_vc;
            end else if (win_type == FT_TAIL) begin
                lock_d    = LK_IDLE;
            end
        end
    end

    // Lock FSM: outputs
    always_comb begin
        lock_active = (lock_q == LK_HELD);
    end

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_flit_d  = tx_flit_q;
        tx_vc_d    = tx_vc_q;
        if (load_en) begin
            tx_valid_d = accept;
            if (accept) begin
                tx_flit_d = win_flit;
                tx_vc_d   = win_vc;
            end
        end
        // Head (01) and single (11) both have bit 0 set; only these advance the pointer.
        ptr_d = (accept && win_type[0]) ? win_next : ptr_q;
    end

    always_comb begin
        logic inc;
        logic dec;
        inc   = 1'b0;
        dec   = 1'b0;
        err_d = err_q;
        if (credit_rx_valid && ({1'b0, credit_rx_vc} >= NUM_VC_L)) begin
            err_d = 1'b1;
        end
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            dec       = in_ready[v];
            inc       = credit_rx_valid && (credit_rx_vc == VC_W'(v));
            cred_d[v] = cred_q[v];
            if (inc && !dec) begin
                if (cred_q[v] == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] + 1'b1;
                end
            end else if (dec && !inc) begin
                cred_d[v] = cred_q[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_flit_q  <= '0;
            tx_vc_q    <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                cred_q[v] <= CRED_MAX;
            end
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_flit_q  <= tx_flit_d;
            tx_vc_q    <= tx_vc_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                cred_q[v] <= cred_d[v];
            end
        end
    end

    always_comb begin
        credit_cnt = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            credit_cnt[v*CNT_W +: CNT_W] = cred_q[v];
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_flit    = tx_flit_q;
    assign tx_vc      = tx_vc_q;
    assign credit_err = err_q;

`ifdef NEBULA_LINK_VC_STATS_EN
    logic [31:0] sflit_q  [NUM_VC];
    logic [31:0] sstall_q [NUM_VC];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                sflit_q[v]  <= '0;
                sstall_q[v] <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (tx_valid_q && rx_ready && (tx_vc_q == VC_W'(v))) begin
                    sflit_q[v] <= sflit_q[v] + 32'd1;
                end
                if (in_valid[v] && (cred_q[v] == '0)) begin
                    sstall_q[v] <= sstall_q[v] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stat_flits = '0;
        stat_stall = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            stat_flits[v*32 +: 32] = sflit_q[v];
            stat_stall[v*32 +: 32] = sstall_q[v];
        end
    end
`endif

endmodule

// File: tb/tb_nebula_link_vc_tx.sv
// Directed bench for nebula_link_vc_tx at default parameters (64-bit flits, 4 VCs, 8 credits).
module tb_nebula_link_vc_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [63:0] fl [4];
    logic [255:0] in_flit;
    logic [3:0]  in_ready;
    logic        tx_valid;
    logic [63:0] tx_flit;
    logic [2:0]  tx_vc;
    logic        rx_ready;
    logic        credit_rx_valid;
    logic [2:0]  credit_rx_vc;
    logic [15:0] credit_cnt;
    logic        credit_err;

    int total = 0;
    int bad   = 0;

    assign in_flit = {fl[3], fl[2], fl[1], fl[0]};

    always #5 clk = ~clk;

    nebula_link_vc_tx dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_flit         (in_flit),
        .in_ready        (in_ready),
        .tx_valid        (tx_valid),
        .tx_flit         (tx_flit),
        .tx_vc           (tx_vc),
        .rx_ready        (rx_ready),
        .credit_rx_valid (credit_rx_valid),
        .credit_rx_vc    (credit_rx_vc),
        .credit_cnt      (credit_cnt),
        .credit_err      (credit_err)
    );

    function automatic logic [63:0] mk(input logic [1:0] t, input logic [7:0] p);
        return {t, 54'd0, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] seq [4];
        logic [2:0] exp_vc;
        seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b00; seq[3] = 2'b10;

        rst = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) fl[i] = mk(2'b11, 8'(i));
        rx_ready = 1'b1;
        credit_rx_valid = 1'b0;
        credit_rx_vc = '0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_tx_valid", 64'(tx_valid), 64'h0);
        chk("rst_tx_flit", tx_flit, 64'h0);
        chk("rst_tx_vc", 64'(tx_vc), 64'h0);
        chk("rst_credits", 64'(credit_cnt), 64'h8888);
        chk("rst_err", 64'(credit_err), 64'h0);
        in_valid = 4'b0000;
        rst = 1'b0;
        tick();

        // single flit on VC0
        fl[0] = mk(2'b11, 8'hA1);
        in_valid = 4'b0001;
        #1;
        chk("t1_in_ready", 64'(in_ready), 64'h1);
        tick();
        chk("t1_tx_valid", 64'(tx_valid), 64'h1);
        chk("t1_tx_vc", 64'(tx_vc), 64'h0);
        chk("t1_tx_flit", tx_flit, mk(2'b11, 8'hA1));
        chk("t1_credit0", 64'(credit_cnt[3:0]), 64'h7);
        in_valid = 4'b0000;
        credit_rx_valid = 1'b1;
        credit_rx_vc = 3'd0;
        tick();
        credit_rx_valid = 1'b0;
        chk("t1_idle_tx_valid", 64'(tx_valid), 64'h0);
        chk("t1_credit_restored", 64'(credit_cnt), 64'h8888);

        // VC0/VC1 alternate until both run out; pointer is 1 after the VC0 single
        fl[0] = mk(2'b11, 8'h10);
        fl[1] = mk(2'b11, 8'h11);
        in_valid = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            exp_vc = (k % 2 == 0) ? 3'd1 : 3'd0;
            #1;
            chk("t2_in_ready", 64'(in_ready), 64'(4'b0001 << exp_vc));
            tick();
            chk("t2_tx_vc", 64'(tx_vc), 64'(exp_vc));
            chk("t2_tx_valid", 64'(tx_valid), 64'h1);
        end
        #1;
        chk("t2_blocked", 64'(in_ready), 64'h0);
        tick();
        chk("t2_tx_valid_after", 64'(tx_valid), 64'h0);
        chk("t2_credits_zero", 64'(credit_cnt), 64'h8800);
        in_valid = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            credit_rx_valid = 1'b1;
            credit_rx_vc = 3'(k % 2);
            tick();
        end
        credit_rx_valid = 1'b0;
        chk("t2_credits_back", 64'(credit_cnt), 64'h8888);
        chk("t2_no_err", 64'(credit_err), 64'h0);

        // VC1 packet is atomic while VC2 waits
        fl[2] = mk(2'b11, 8'h22);
        in_valid = 4'b0110;
        for (int j = 0; j < 4; j++) begin
            fl[1] = mk(seq[j], 8'(8'h30 + j));
            #1;
            chk("t3_in_ready", 64'(in_ready), 64'h2);
            tick();
            chk("t3_tx_vc", 64'(tx_vc), 64'h1);
            chk("t3_tx_flit", tx_flit, mk(seq[j], 8'(8'h30 + j)));
        end
        in_valid = 4'b0100;
        #1;
        chk("t3_vc2_ready", 64'(in_ready), 64'h4);
        tick();
        chk("t3_vc2_tx_vc", 64'(tx_vc), 64'h2);
        chk("t3_vc2_tx_flit", tx_flit, mk(2'b11, 8'h22));
        chk("t3_credits", 64'(credit_cnt), 64'h8748);

        // backpressure holds the output register
        rx_ready = 1'b0;
        fl[0] = mk(2'b11, 8'h55);
        in_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_in_ready", 64'(in_ready), 64'h0);
            tick();
            chk("t4_hold_valid", 64'(tx_valid), 64'h1);
            chk("t4_hold_vc", 64'(tx_vc), 64'h2);
            chk("t4_hold_flit", tx_flit, mk(2'b11, 8'h22));
        end
        rx_ready = 1'b1;
        #1;
        chk("t4_release_ready", 64'(in_ready), 64'h1);
        tick();
        chk("t4_next_vc", 64'(tx_vc), 64'h0);
        chk("t4_next_flit", tx_flit, mk(2'b11, 8'h55));
        in_valid = 4'b0000;
        tick();

        // VC2 credit starvation and return timing
        fl[2] = mk(2'b11, 8'h66);
        in_valid = 4'b0100;
        for (int k = 0; k < 7; k++) tick();
        #1;
        chk("t5_starved_ready", 64'(in_ready), 64'h0);
        chk("t5_credit2_zero", 64'(credit_cnt[11:8]), 64'h0);
        credit_rx_valid = 1'b1;
        credit_rx_vc = 3'd2;
        #1;
        chk("t5_ready_cycle_n", 64'(in_ready), 64'h0);
        tick();
        credit_rx_valid = 1'b0;
        #1;
        chk("t5_ready_cycle_n1", 64'(in_ready), 64'h4);
        chk("t5_credit2_one", 64'(credit_cnt[11:8]), 64'h1);
        credit_rx_valid = 1'b1;
        credit_rx_vc = 3'd2;
        tick();
        credit_rx_valid = 1'b0;
        in_valid = 4'b0000;
        chk("t5_consume_return", 64'(credit_cnt[11:8]), 64'h1);
        chk("t5_tx_vc", 64'(tx_vc), 64'h2);
        tick();

        // credit return errors
        credit_rx_valid = 1'b1;
        credit_rx_vc = 3'd3;
        tick();
        credit_rx_valid = 1'b0;
        chk("t6_sat_count", 64'(credit_cnt[15:12]), 64'h8);
        chk("t6_sat_err", 64'(credit_err), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_err_cleared", 64'(credit_err), 64'h0);
        chk("t6_credits_reset", 64'(credit_cnt), 64'h8888);
        credit_rx_valid = 1'b1;
        credit_rx_vc = 3'd5;
        tick();
        credit_rx_valid = 1'b0;
        chk("t6_badvc_err", 64'(credit_err), 64'h1);
        chk("t6_badvc_counts", 64'(credit_cnt), 64'h8888);
        tick();
        tick();
        tick();
        chk("t6_err_sticky", 64'(credit_err), 64'h1);

        // reset mid-packet drops lock and held flit
        fl[0] = mk(2'b01, 8'h77);
        in_valid = 4'b0001;
        tick();
        chk("t7_head_out", 64'(tx_valid), 64'h1);
        rx_ready = 1'b0;
        in_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx_ready = 1'b1;
        chk("t7_rst_tx_valid", 64'(tx_valid), 64'h0);
        chk("t7_rst_tx_flit", tx_flit, 64'h0);
        chk("t7_rst_err", 64'(credit_err), 64'h0);
        fl[1] = mk(2'b11, 8'h88);
        in_valid = 4'b0010;
        #1;
        chk("t7_unlocked_ready", 64'(in_ready), 64'h2);
        tick();
        chk("t7_tx_vc", 64'(tx_vc), 64'h1);
        chk("t7_tx_flit", tx_flit, mk(2'b11, 8'h88));
        in_valid = 4'b0000;
        tick();
        chk("t7_idle", 64'(tx_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
